// File: rtl/uart_rx_core.sv
// UART receive engine: 2-FF synchronised rxd, 3-sample majority vote at mid-bit,
// LSB-first deserialisation, valid/ready word hand-off with framing/parity/overrun status.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 sample_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam bit PEN = (PARITY_EN != 0);
  localparam bit POD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nx;
  logic [TW-1:0]        tick_cnt, tick_nx;
  logic [BW-1:0]        bit_cnt, bit_nx;
  logic                 rxd_s1, rxd_s2;
  logic [1:0]           vote_sr;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 vote, dec_tick, end_tick;
  logic                 shift_en, par_cap, word_done, perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1  <= 1'b1;
      rxd_s2  <= 1'b1;
      vote_sr <= 2'b11;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      if (sample_tick) vote_sr <= {vote_sr[0], rxd_s2};
    end
  end

  // vote_sr holds the two previous ticks, so on the decision tick the live
  // sample completes the trio at OVERSAMPLE/2-1 .. OVERSAMPLE/2+1
  assign vote     = (vote_sr[1] & vote_sr[0]) | (vote_sr[1] & rxd_s2) | (vote_sr[0] & rxd_s2);
  assign dec_tick = sample_tick && (tick_cnt == T_DEC);
  assign end_tick = sample_tick && (tick_cnt == T_LAST);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx  = state;
    tick_nx   = tick_cnt;
    bit_nx    = bit_cnt;
    shift_en  = 1'b0;
    par_cap   = 1'b0;
    word_done = 1'b0;
    if (!rx_en) begin
      state_nx = IDLE;
      tick_nx  = '0;
      bit_nx   = '0;
    end else begin
      if (sample_tick && state != IDLE)
        tick_nx = (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
      unique case (state)
        IDLE: begin
          if (sample_tick && !rxd_s2) begin
            state_nx = START;
            tick_nx  = '0;
            bit_nx   = '0;
          end
        end
        START: begin
          if (dec_tick && vote) begin
            state_nx = IDLE;
            tick_nx  = '0;
          end else if (end_tick) begin
            state_nx = DATA;
            bit_nx   = '0;
          end
        end
        DATA: begin
          shift_en = dec_tick;
          if (end_tick) begin
            if (bit_cnt == B_LAST) state_nx = PEN ? PARITY : STOP;
            else                   bit_nx   = bit_cnt + BW'(1);
          end
        end
        PARITY: begin
          par_cap = dec_tick;
          if (end_tick) state_nx = STOP;
        end
        STOP: begin
          // finish at mid stop bit so the next start edge is never missed
          if (dec_tick) begin
            word_done = 1'b1;
            state_nx  = IDLE;
            tick_nx   = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      bit_cnt  <= bit_nx;
      if (shift_en) shreg   <= {vote, shreg[DATA_BITS-1:1]};
      if (par_cap)  par_bit <= vote;
    end
  end

  assign perr = PEN && ((^shreg ^ par_bit) != POD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= ~vote;
          parity_err <= perr;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and an 8E1 instance, frames driven bit-serially,
// received words checked against an expected-word queue at each handshake.
module tb_uart_rx_core;

  logic       clk, rst_n, rx_en, sample_tick, rx_ready;
  logic       rxd, rxd_p;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .sample_tick(sample_tick), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .busy(busy));

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .sample_tick(sample_tick), .rxd(rxd_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready), .frame_err(frame_err_p),
    .parity_err(parity_err_p), .overrun(overrun_p), .busy(busy_p));

  typedef struct packed {logic [7:0] d; logic fe; logic pe;} exp_t;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         glitch;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  exp_t q[$], qp[$];
  int   n_chk = 0, n_fail = 0, nw = 0, ov_cnt = 0;
  bit   hs_prev = 0;
  int   tdiv = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // sample_tick every 4 clk, driven just after the active edge
  initial begin
    sample_tick = 0;
    forever begin
      @(posedge clk); #1;
      tdiv = (tdiv + 1) % 4;
      sample_tick = (tdiv == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: end of test not reached within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // one bit period = 16 ticks = 64 clk; glitch inverts the line for one tick at mid-bit
  task automatic drive_bit(input bit which, input logic v, input bit glitch);
    logic x;
    for (int c = 0; c < 64; c++) begin
      x = (glitch && c >= 36 && c < 40) ? ~v : v;
      if (which) rxd_p = x; else rxd = x;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input logic stop,
                            input bit pen, input logic par, input int gbit);
    drive_bit(which, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], (i == gbit));
    if (pen) drive_bit(which, par, 1'b0);
    drive_bit(which, stop, 1'b0);
    if (which) rxd_p = 1'b1; else rxd = 1'b1;
  endtask

  // scoreboard for the 8N1 instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (hs_prev) chk("valid_drop_after_handshake", rx_valid, 0);
      hs_prev = 0;
      if (overrun) ov_cnt++;
      if (rst_n && rx_valid && rx_ready) begin
        nw++;
        hs_prev = 1;
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_word: got %0h, expected no word", rx_data);
        end else begin
          e = q.pop_front();
          chk("rx_word{data,fe,pe}", {rx_data, frame_err, parity_err}, {e.d, e.fe, e.pe});
        end
      end
    end
  end

  // scoreboard for the parity instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rx_valid_p && rx_ready) begin
        if (qp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_word_p: got %0h, expected no word", rx_data_p);
        end else begin
          e = qp.pop_front();
          chk("rx_word_p{data,fe,pe}", {rx_data_p, frame_err_p, parity_err_p}, {e.d, e.fe, e.pe});
        end
      end
    end
  end

  initial begin
    vec_t vecs[5];
    int   w0;
    logic [7:0] pd;
    vecs[0] = '{8'hA5, 1'b1, -1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b1,  3, 8'h3C, 1'b0};
    vecs[2] = '{8'h00, 1'b0, -1, 8'h00, 1'b1};
    vecs[3] = '{8'h5A, 1'b1, -1, 8'h5A, 1'b0};
    vecs[4] = '{8'hFF, 1'b1,  6, 8'hFF, 1'b0};

    rst_n = 0; rx_en = 1; rxd = 1; rxd_p = 1; rx_ready = 1;
    idle(3);
    chk("reset_outputs", {rx_data, rx_valid, frame_err, parity_err, overrun, busy}, 0);
    chk("reset_outputs_p", {rx_data_p, rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p}, 0);
    rst_n = 1;
    idle(64);

    for (int i = 0; i < 5; i++) begin
      q.push_back('{vecs[i].exp_data, vecs[i].exp_fe, 1'b0});
      send_frame(0, vecs[i].data, vecs[i].stop, 0, 1'b0, vecs[i].glitch);
      idle(128);
      chk("busy_idle_after_frame", busy, 0);
    end

    // false start: 3 low ticks then high
    w0 = nw;
    rxd = 0;
    idle(12);
    chk("false_start_busy", busy, 1);
    rxd = 1;
    for (int c = 0; c < 64 && busy; c++) idle(1);
    chk("false_start_returns_idle", busy, 0);
    idle(64);
    chk("false_start_no_word", nw, w0);

    // even parity: 0x07 has three ones
    qp.push_back('{8'h07, 1'b0, 1'b1});
    send_frame(1, 8'h07, 1'b1, 1, 1'b0, -1);
    idle(128);
    qp.push_back('{8'h07, 1'b0, 1'b0});
    send_frame(1, 8'h07, 1'b1, 1, 1'b1, -1);
    idle(128);

    // overrun: second word dropped while the first is held
    rx_ready = 0;
    ov_cnt = 0;
    q.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(0, 8'h11, 1'b1, 0, 1'b0, -1);
    send_frame(0, 8'h22, 1'b1, 0, 1'b0, -1);
    idle(64);
    chk("overrun_pulse_count", ov_cnt, 1);
    chk("overrun_held_valid", rx_valid, 1);
    chk("overrun_held_data", rx_data, 8'h11);
    rx_ready = 1;
    idle(4);
    chk("overrun_released", rx_valid, 0);

    // rx_en dropped during data bit 3
    w0 = nw;
    pd = 8'h6B;
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, pd[i], 1'b0);
    rxd = pd[3];
    idle(20);
    chk("rx_en_busy_before", busy, 1);
    rx_en = 0;
    idle(1);
    chk("rx_en_busy_after", busy, 0);
    rxd = 1;
    idle(64);
    rx_en = 1;
    idle(128);
    chk("rx_en_no_word", nw, w0);
    chk("rx_en_no_overrun", ov_cnt, 1);

    // reset mid-frame loses the held word
    rx_ready = 0;
    send_frame(0, 8'h33, 1'b1, 0, 1'b0, -1);
    idle(64);
    chk("held_before_reset", {rx_valid, rx_data}, {1'b1, 8'h33});
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    rxd = 0;
    idle(10);
    rst_n = 0;
    #1;
    chk("reset_midframe_outputs", {rx_data, rx_valid, frame_err, parity_err, overrun, busy}, 0);
    rxd = 1;
    idle(4);
    rst_n = 1;
    rx_ready = 1;
    idle(64);
    chk("after_reset_no_valid", rx_valid, 0);
    q.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(0, 8'h81, 1'b1, 0, 1'b0, -1);
    idle(128);

    chk("all_expected_words_seen", q.size() + qp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
